// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide controller.
//   md_op_t      - E-stage MD operation codes (3 bits)
//   md_state_t   - controller state encoding
//   *_CYC_DEF    - default busy latencies for multiply and divide
//   is_mdu_op()  - true for ops that occupy the arithmetic unit
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // MTHI/MTLO complete in one edge; only these four start a busy period.
  function automatic logic is_mdu_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle MULT/DIV unit with architectural HI/LO registers.
// The 64-bit result is computed combinationally at the start edge and parked
// in a pending register; HI/LO only see it when the busy countdown expires.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   E_md_start, E_md_op   - E-stage MD op request (valid, not stalled) and opcode
//   E_rsValue, E_rtValue  - forwarded operands
//   D_md_use              - D-stage instruction touches HI/LO or the MD unit
//   md_busy               - MULT/DIV in flight
//   D_stall               - freeze PC/D, bubble E
//   HI, LO                - architectural HI/LO registers
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_md_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rsValue,
  input  logic [31:0] E_rtValue,
  input  logic        D_md_use,
  output logic        md_busy,
  output logic        D_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYC - 1);

  // Signed divide returning {remainder, quotient}. The one overflowing case
  // (most negative / -1) is pinned explicitly so no tool evaluates it.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'sd0) begin
      q = 32'sd0;
      r = 32'sd0;
    end else if ((a == 32'sh8000_0000) && (b == -32'sd1)) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  md_state_t   state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [63:0] pend_p1, pend_nx;
  // Qualifies the pending result: cleared for divide-by-zero so HI/LO hold.
  logic        pend_vld_p1, pend_vld_nx;

  assign rs_s   = E_rsValue;
  assign rt_s   = E_rtValue;
  assign prod_s = 64'(rs_s) * 64'(rt_s);
  assign prod_u = {32'd0, E_rsValue} * {32'd0, E_rtValue};

  assign md_busy = (state == ST_BUSY);
  assign D_stall = D_md_use & (md_busy | (E_md_start & is_mdu_op(E_md_op)));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    hi_nx       = HI;
    lo_nx       = LO;
    pend_nx     = pend_p1;
    pend_vld_nx = pend_vld_p1;
    case (state)
      ST_IDLE: begin
        if (E_md_start) begin
          case (E_md_op)
            MD_MULT: begin
              state_nx    = ST_BUSY;
              cnt_nx      = MULT_LAT;
              pend_nx     = prod_s;
              pend_vld_nx = 1'b1;
            end
            MD_MULTU: begin
              state_nx    = ST_BUSY;
              cnt_nx      = MULT_LAT;
              pend_nx     = prod_u;
              pend_vld_nx = 1'b1;
            end
            MD_DIV: begin
              state_nx    = ST_BUSY;
              cnt_nx      = DIV_LAT;
              pend_nx     = div_signed(rs_s, rt_s);
              pend_vld_nx = (E_rtValue != 32'd0);
            end
            MD_DIVU: begin
              state_nx    = ST_BUSY;
              cnt_nx      = DIV_LAT;
              pend_nx     = div_unsigned(E_rsValue, E_rtValue);
              pend_vld_nx = (E_rtValue != 32'd0);
            end
            MD_MTHI: hi_nx = E_rsValue;
            MD_MTLO: lo_nx = E_rsValue;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // Starts arriving here are dropped: the pipeline must not issue them.
        if (cnt == 4'd0) begin
          state_nx = ST_IDLE;
          if (pend_vld_p1) begin
            hi_nx = pend_p1[63:32];
            lo_nx = pend_p1[31:0];
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      HI          <= 32'd0;
      LO          <= 32'd0;
      pend_p1     <= 64'd0;
      pend_vld_p1 <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      HI          <= hi_nx;
      LO          <= lo_nx;
      pend_p1     <= pend_nx;
      pend_vld_p1 <= pend_vld_nx;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed + randomized bench for md_ctrl. The reference model
// computes HI/LO with 64-bit integer arithmetic and tracks busy duration by
// operation latency only.
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        E_md_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_rsValue;
  logic [31:0] E_rtValue;
  logic        D_md_use;
  logic        md_busy;
  logic        D_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_md_start (E_md_start),
    .E_md_op    (E_md_op),
    .E_rsValue  (E_rsValue),
    .E_rtValue  (E_rtValue),
    .D_md_use   (D_md_use),
    .md_busy    (md_busy),
    .D_stall    (D_stall),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [2:0] op);
    case (op)
      MD_MULT, MD_MULTU: return MC;
      MD_DIV, MD_DIVU:   return DC;
      default:           return 0;
    endcase
  endfunction

  // Architectural effect of one op on HI/LO, from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MD_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op; optionally inject an illegal start at busy cycle 'intrude'.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dmu, input int intrude);
    logic [31:0] old_hi, old_lo;
    int L;
    L = lat(op);
    old_hi = m_hi;
    old_lo = m_lo;
    model(op, a, b);
    D_md_use   = dmu;
    E_md_start = 1'b1;
    E_md_op    = op;
    E_rsValue  = a;
    E_rtValue  = b;
    #1;
    check("stall_at_start", {31'd0, D_stall}, {31'd0, dmu && (L != 0)});
    tick();
    E_md_start = 1'b0;
    for (int i = 0; i < L; i++) begin
      check("busy_during", {31'd0, md_busy}, 32'd1);
      check("stall_during", {31'd0, D_stall}, {31'd0, dmu});
      check("hi_stable", HI, old_hi);
      check("lo_stable", LO, old_lo);
      if (i == intrude) begin
        E_md_start = 1'b1;
        E_md_op    = MD_MTLO;
        E_rsValue  = 32'hDEAD_BEEF;
      end
      tick();
      E_md_start = 1'b0;
    end
    check("busy_after", {31'd0, md_busy}, 32'd0);
    check("stall_after", {31'd0, D_stall}, 32'd0);
    check("hi_result", HI, m_hi);
    check("lo_result", LO, m_lo);
    D_md_use = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    E_md_start = 1'b0;
    E_md_op    = 3'd0;
    E_rsValue  = 32'd0;
    E_rtValue  = 32'd0;
    D_md_use   = 1'b1;
    #3;
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_stall", {31'd0, D_stall}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    D_md_use = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // MULT signed: -2 * 3
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
    check("mult_neg_hi", HI, 32'hFFFF_FFFF);
    check("mult_neg_lo", LO, 32'hFFFF_FFFA);

    // DIVU 100/7 with a dependent D-stage instruction
    run_op(MD_DIVU, 32'd100, 32'd7, 1'b1, -1);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // Divide by zero keeps previously moved-in values
    run_op(MD_MTHI, 32'h1234, 32'd0, 1'b0, -1);
    run_op(MD_MTLO, 32'h5678, 32'd0, 1'b0, -1);
    run_op(MD_DIV, 32'd5, 32'd0, 1'b1, -1);
    check("div0_hi", HI, 32'h1234);
    check("div0_lo", LO, 32'h5678);

    // Signed truncation and the overflow corner
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);

    // MTLO while idle with D_md_use: no stall, no busy
    run_op(MD_MTLO, 32'hA5, 32'd0, 1'b1, -1);
    check("mtlo_lo", LO, 32'hA5);

    // Starts during BUSY (mid-way and on the completion cycle) are ignored
    run_op(MD_MULTU, 32'd7, 32'd9, 1'b0, 2);
    check("intrude_mid_lo", LO, 32'd63);
    run_op(MD_MULT, 32'd5, 32'd5, 1'b1, MC - 1);
    check("intrude_last_lo", LO, 32'd25);

    // Reset at busy cycle 3 of MULT 2x3 aborts the operation
    run_op(MD_MTHI, 32'h1111, 32'd0, 1'b0, -1);
    E_md_start = 1'b1;
    E_md_op    = MD_MULT;
    E_rsValue  = 32'd2;
    E_rtValue  = 32'd3;
    tick();
    E_md_start = 1'b0;
    D_md_use   = 1'b1;
    tick();
    tick();
    check("pre_abort_busy", {31'd0, md_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, md_busy}, 32'd0);
    check("abort_stall", {31'd0, D_stall}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    reset_n  = 1'b1;
    D_md_use = 1'b0;
    for (int i = 0; i < MC + 3; i++) tick();
    check("post_abort_busy", {31'd0, md_busy}, 32'd0);
    check("post_abort_hi", HI, 32'd0);
    check("post_abort_lo", LO, 32'd0);

    // Randomized ops against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        dmu;
      int          intr;
      op  = 3'($urandom_range(0, 5));
      a   = $urandom;
      if ($urandom_range(0, 7) == 0)      b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else                                b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      dmu  = 1'($urandom_range(0, 1));
      intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_op(op, a, b, dmu, intr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
